mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Four-requester arbiter sharing one downstream memory port (ram, cache, spm, ...).
//  Each requester sees a standard memory port (addr/din/dout/re/we/ready); requests are
//  latched per port and issued to the downstream port one at a time, round-robin.
//  Sits between independent masters (e.g. CPU I/D, DMA) and a single memory hierarchy.
// PARAMETERS
//  ADDR_WIDTH  64  address width, all ports
//  WORD_WIDTH  64  data width, all ports
// PORTS
//  clk        input   1           clock, all state updates on posedge
//  rst        input   1           async reset, active-high
//  pN_addr    input   ADDR_WIDTH  requester N address (N = 0..3, one port each)
//  pN_din     input   WORD_WIDTH  requester N write data
//  pN_dout    output  WORD_WIDTH  requester N read data; valid while pN_ready=1 after a read
//  pN_re      input   1           requester N read strobe (1 cycle)
//  pN_we      input   1           requester N write strobe (1 cycle)
//  pN_ready   output  1           requester N idle / request complete
//  mem_addr   output  ADDR_WIDTH  downstream address
//  mem_din    output  WORD_WIDTH  downstream write data
//  mem_dout   input   WORD_WIDTH  downstream read data
//  mem_re     output  1           downstream read strobe
//  mem_we     output  1           downstream write strobe
//  mem_ready  input   1           downstream ready
// BEHAVIOUR
//  - Clock clk; reset rst asynchronous, active-high; every flop clears on posedge rst.
//  - Reset values: pN_ready=1, pN_dout=0, mem_re=0, mem_we=0, mem_addr=0, mem_din=0,
//    all pending flags 0, RR pointer=0, FSM=IDLE.
//  - Accept: at posedge with (pN_re|pN_we)&pN_ready -> latch addr/din/op, set pendN,
//    pN_ready=0 from next cycle. re+we together -> write only. Strobes while pN_ready=0 ignored.
//  - FSM IDLE: if mem_ready=1 and any pend -> pick winner, register mem_addr/mem_din and
//    mem_re or mem_we=1, record grant; -> ISSUE. No pend or mem_ready=0 -> stay IDLE.
//  - ISSUE (1 cycle): mem_re=mem_we=0 at next edge; -> WAIT.
//  - WAIT: downstream drops mem_ready the cycle after sampling the strobe. At first edge with
//    mem_ready=1: read -> pN_dout<=mem_dout; write -> pN_dout unchanged; pN_ready<=1,
//    clear pendN, RR pointer <= grant+1 (mod 4); -> IDLE.
//  - Arbitration: first pending port scanning ptr, ptr+1, ... (wrap 3->0).
//  - Latency: requester strobe at edge E0 -> mem strobe visible after E1 (if idle) ->
//    pN_ready=1 one edge after mem_ready returns high. Back-to-back grants: one IDLE cycle.
//  - Same-edge events: new accepts on other ports and completion on the granted port both
//    take effect; a port completing at edge E may strobe again from E+1.
//  - mem_addr/mem_din hold last issued values between requests.
//  - Reset mid-operation: pending requests discarded, strobes dropped; downstream shares rst.
// CONFIGURATION
//  ARB_FIXED_PRI_EN defined: fixed priority, port 0 highest, 3 lowest; RR pointer absent.
//  Not defined (default): round-robin as above. Handshake and latency identical both ways.
// TESTING
//  1. rst 2 cycles -> all pN_ready=1, mem_re=mem_we=0, pN_dout=0.
//  2. p0 write addr 1 = 64'h0123456789abcdef into ram -> p0_ready=0 next cycle, mem_we
//     one cycle, p0_ready=1 after ram done; p0 read addr 1 -> p0_dout=64'h0123456789abcdef.
//  3. Preload 10..13 = 100..103; p0..p3 read 10..13 same cycle -> mem_re order 0,1,2,3;
//     pN_dout = 100+N; only one mem strobe in flight at any time.
//  4. p0 re-requests on every completion, p1 pending -> grants 0,1,0,1 (round-robin);
//     with ARB_FIXED_PRI_EN, p0 served repeatedly, p1 only when p0 idle.
//  5. p2 re while p2_ready=0 -> ignored (one mem_re); p3 re+we same cycle addr 20 data 7
//     -> mem_we only; later p3 read 20 -> 7.
//  6. rst during WAIT with p1,p2 pending -> all pN_ready=1, no further mem strobes; new
//     p1 read afterwards completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Four requester ports share one downstream memory port. Each requester
//   strobe is latched into a per-port slot. One slot at a time is issued to
//   the downstream port. The issue order is round-robin by default.
//
//   Build option: define ARB_FIXED_PRI_EN to select fixed priority (port 0
//   highest, port 3 lowest). In that build the round-robin pointer does not
//   exist. The handshake and the latency are the same in both builds.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   pN_addr/pN_din    requester N address / write data          (N = 0..3)
//   pN_re/pN_we       requester N one-cycle read / write strobe
//   pN_dout           requester N read data, held while pN_ready=1
//   pN_ready          requester N idle (no request outstanding)
//   mem_addr/mem_din  downstream address / write data, hold last issued values
//   mem_re/mem_we     downstream one-cycle read / write strobe
//   mem_dout          downstream read data
//   mem_ready         downstream ready
//   o_dbg_state       current FSM state (IDLE=0, ISSUE=1, WAIT=2)
//
// Handshake
//   Requester side: a strobe is accepted on a posedge only while pN_ready=1.
//   pN_ready drops on the following cycle. It rises again on the edge the
//   downstream completes. Strobes seen while pN_ready=0 are dropped. If re
//   and we arrive together, the request is a write.
//   Downstream side: a strobe is issued only when mem_ready=1 and lasts one
//   cycle. The transfer completes at the first later edge with mem_ready=1.
//   This relies on the downstream dropping mem_ready on the cycle after it
//   samples the strobe.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [WORD_WIDTH-1:0] p0_din,
  output logic [WORD_WIDTH-1:0] p0_dout,
  input  logic                  p0_re,
  input  logic                  p0_we,
  output logic                  p0_ready,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [WORD_WIDTH-1:0] p1_din,
  output logic [WORD_WIDTH-1:0] p1_dout,
  input  logic                  p1_re,
  input  logic                  p1_we,
  output logic                  p1_ready,
  input  logic [ADDR_WIDTH-1:0] p2_addr,
  input  logic [WORD_WIDTH-1:0] p2_din,
  output logic [WORD_WIDTH-1:0] p2_dout,
  input  logic                  p2_re,
  input  logic                  p2_we,
  output logic                  p2_ready,
  input  logic [ADDR_WIDTH-1:0] p3_addr,
  input  logic [WORD_WIDTH-1:0] p3_din,
  output logic [WORD_WIDTH-1:0] p3_dout,
  input  logic                  p3_re,
  input  logic                  p3_we,
  output logic                  p3_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_din,
  input  logic [WORD_WIDTH-1:0] mem_dout,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Requester inputs gathered into arrays so per-port logic is a loop.
  logic [ADDR_WIDTH-1:0] w_in_addr [4];
  logic [WORD_WIDTH-1:0] w_in_din  [4];
  logic [3:0]            w_in_re;
  logic [3:0]            w_in_we;

  assign w_in_addr[0] = p0_addr;
  assign w_in_addr[1] = p1_addr;
  assign w_in_addr[2] = p2_addr;
  assign w_in_addr[3] = p3_addr;
  assign w_in_din[0]  = p0_din;
  assign w_in_din[1]  = p1_din;
  assign w_in_din[2]  = p2_din;
  assign w_in_din[3]  = p3_din;
  assign w_in_re      = {p3_re, p2_re, p1_re, p0_re};
  assign w_in_we      = {p3_we, p2_we, p1_we, p0_we};

  // Per-port request slots
  logic [ADDR_WIDTH-1:0] r_addr  [4];
  logic [WORD_WIDTH-1:0] r_din   [4];
  logic [WORD_WIDTH-1:0] r_dout  [4];
  logic [3:0]            r_pend;
  logic [3:0]            r_op_we;

  // Downstream side
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [WORD_WIDTH-1:0] r_mem_din;
  logic                  r_mem_re;
  logic                  r_mem_we;
  logic [1:0]            r_grant;
`ifndef ARB_FIXED_PRI_EN
  logic [1:0]            r_ptr;
`endif

  state_t     r_state;
  state_t     w_next_state;
  logic       w_issue;
  logic       w_complete;
  logic       w_found;
  logic [1:0] w_winner;
  logic [3:0] w_accept;

  // A slot accepts a new strobe only while it is empty (pN_ready=1).
  assign w_accept = (w_in_re | w_in_we) & ~r_pend;

  // Winner selection: the first pending slot in scan order.
  always_comb begin : arb_scan
    logic [1:0] idx;
    w_found  = 1'b0;
    w_winner = 2'd0;
    idx      = 2'd0;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRI_EN
      idx = 2'(i);
`else
      idx = r_ptr + 2'(i);
`endif
      if (!w_found && r_pend[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state and control pulses
  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_ready && w_found) begin
          w_issue      = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready) begin
          w_complete   = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Request slots. An accept and a completion can never target the same
  // slot on one edge: an accept needs the slot empty, a completion needs it
  // full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= 4'b0000;
      r_op_we <= 4'b0000;
      for (int n = 0; n < 4; n++) begin
        r_addr[n] <= '0;
        r_din[n]  <= '0;
        r_dout[n] <= '0;
      end
`ifndef ARB_FIXED_PRI_EN
      r_ptr <= 2'd0;
`endif
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_accept[n]) begin
          r_pend[n]  <= 1'b1;
          r_op_we[n] <= w_in_we[n];
          r_addr[n]  <= w_in_addr[n];
          r_din[n]   <= w_in_din[n];
        end
      end
      if (w_complete) begin
        r_pend[r_grant] <= 1'b0;
        if (!r_op_we[r_grant]) begin
          r_dout[r_grant] <= mem_dout;
        end
`ifndef ARB_FIXED_PRI_EN
        r_ptr <= r_grant + 2'd1;
`endif
      end
    end
  end

  // Downstream issue. The strobes are high only during ISSUE.
  // Address and data hold their last issued values between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_re   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_grant    <= 2'd0;
    end else if (w_issue) begin
      r_mem_addr <= r_addr[w_winner];
      r_mem_din  <= r_din[w_winner];
      r_mem_re   <= ~r_op_we[w_winner];
      r_mem_we   <= r_op_we[w_winner];
      r_grant    <= w_winner;
    end else begin
      r_mem_re   <= 1'b0;
      r_mem_we   <= 1'b0;
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_din     = r_mem_din;
  assign mem_re      = r_mem_re;
  assign mem_we      = r_mem_we;
  assign p0_ready    = ~r_pend[0];
  assign p1_ready    = ~r_pend[1];
  assign p2_ready    = ~r_pend[2];
  assign p3_ready    = ~r_pend[3];
  assign p0_dout     = r_dout[0];
  assign p1_dout     = r_dout[1];
  assign p2_dout     = r_dout[2];
  assign p3_dout     = r_dout[3];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a small downstream memory model.
//   Expected downstream strobes and requester completions are queued at issue
//   time. A monitor on the falling edge pops and compares them as they appear.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] din;
  } gnt_t;

  typedef struct packed {
    logic [1:0]  port;
    logic [63:0] data;
  } cmp_t;

  localparam logic [63:0] WDATA = 64'h0123456789abcdef;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [63:0] t_addr [4];
  logic [63:0] t_din  [4];
  logic [3:0]  t_re;
  logic [3:0]  t_we;
  logic [63:0] dout_w [4];
  logic [3:0]  rdy;
  logic [63:0] mem_addr;
  logic [63:0] mem_din;
  logic [63:0] m_dout;
  logic        mem_re;
  logic        mem_we;
  logic        m_ready;
  logic [1:0]  dbg_state;

  mem_arbiter #(.ADDR_WIDTH(64), .WORD_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(t_addr[0]), .p0_din(t_din[0]), .p0_dout(dout_w[0]),
    .p0_re(t_re[0]), .p0_we(t_we[0]), .p0_ready(rdy[0]),
    .p1_addr(t_addr[1]), .p1_din(t_din[1]), .p1_dout(dout_w[1]),
    .p1_re(t_re[1]), .p1_we(t_we[1]), .p1_ready(rdy[1]),
    .p2_addr(t_addr[2]), .p2_din(t_din[2]), .p2_dout(dout_w[2]),
    .p2_re(t_re[2]), .p2_we(t_we[2]), .p2_ready(rdy[2]),
    .p3_addr(t_addr[3]), .p3_din(t_din[3]), .p3_dout(dout_w[3]),
    .p3_re(t_re[3]), .p3_we(t_we[3]), .p3_ready(rdy[3]),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(m_dout),
    .mem_re(mem_re), .mem_we(mem_we), .mem_ready(m_ready),
    .o_dbg_state(dbg_state)
  );

  // ---------------- downstream memory model ----------------
  // Drops ready on the edge that samples a strobe, then stays busy for
  // m_lat+1 cycles. Shares the reset with the DUT.
  logic [63:0] m_arr [256];
  int          m_lat = 2;
  int          m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_cnt   <= 0;
      m_dout  <= 64'd0;
    end else if (m_ready && (mem_re || mem_we)) begin
      m_ready <= 1'b0;
      m_cnt   <= m_lat;
      if (mem_we) m_arr[mem_addr[7:0]] <= mem_din;
      else        m_dout <= m_arr[mem_addr[7:0]];
    end else if (!m_ready) begin
      if (m_cnt == 0) m_ready <= 1'b1;
      else            m_cnt   <= m_cnt - 1;
    end
  end

  // ---------------- scoreboard ----------------
  gnt_t exp_gnt_q [$];
  cmp_t exp_cmp_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_g(input logic we, input logic [63:0] addr, input logic [63:0] din);
    gnt_t g;
    g.we = we; g.addr = addr; g.din = din;
    exp_gnt_q.push_back(g);
  endtask

  task automatic push_c(input logic [1:0] port, input logic [63:0] data);
    cmp_t c;
    c.port = port; c.data = data;
    exp_cmp_q.push_back(c);
  endtask

  // Monitor: downstream strobes and rising pN_ready edges.
  initial begin : monitor
    logic [3:0] prev_rdy;
    gnt_t g;
    cmp_t c;
    prev_rdy = 4'hf;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rdy = 4'hf;
      end else begin
        if (mem_re || mem_we) begin
          check("strobe_exclusive", 64'(mem_re & mem_we), 64'd0);
          check("strobe_while_mem_ready", 64'(m_ready), 64'd1);
          if (exp_gnt_q.size() == 0) begin
            check("unexpected_strobe_addr", mem_addr, 64'hffff_ffff_ffff_ffff);
          end else begin
            g = exp_gnt_q.pop_front();
            check("grant_we", 64'(mem_we), 64'(g.we));
            check("grant_addr", mem_addr, g.addr);
            if (g.we) check("grant_din", mem_din, g.din);
          end
        end
        for (int n = 0; n < 4; n++) begin
          if (rdy[n] && !prev_rdy[n]) begin
            if (exp_cmp_q.size() == 0) begin
              check("unexpected_completion_port", 64'(n), 64'hffff_ffff_ffff_ffff);
            end else begin
              c = exp_cmp_q.pop_front();
              check("completion_port", 64'(n), 64'(c.port));
              check("completion_dout", dout_w[n], c.data);
            end
          end
        end
        prev_rdy = rdy;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Callers are at a falling edge. req drives a port's strobe at once, and
  // pulse holds all strobes for one rising edge.
  task automatic req(input int n, input logic re, input logic we,
                     input logic [63:0] addr, input logic [63:0] din);
    t_re[n]   = re;
    t_we[n]   = we;
    t_addr[n] = addr;
    t_din[n]  = din;
  endtask

  task automatic pulse();
    @(negedge clk);
    t_re = 4'b0000;
    t_we = 4'b0000;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((exp_gnt_q.size() != 0 || exp_cmp_q.size() != 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("queues_drained", 64'(exp_gnt_q.size() + exp_cmp_q.size()), 64'd0);
    exp_gnt_q.delete();
    exp_cmp_q.delete();
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_rise(input int n);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (rdy[n] !== 1'b1 && cyc < 500);
    check("ready_returns", 64'(rdy[n]), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    rst  = 1'b1;
    t_re = 4'b0000;
    t_we = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      t_addr[n] = 64'd0;
      t_din[n]  = 64'd0;
    end

    // 1. reset state
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(rdy), 64'hf);
    check("reset_mem_re", 64'(mem_re), 64'd0);
    check("reset_mem_we", 64'(mem_we), 64'd0);
    check("reset_mem_addr", mem_addr, 64'd0);
    for (int n = 0; n < 4; n++) check("reset_dout", dout_w[n], 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 2. p0 write then read back
    push_g(1'b1, 64'd1, WDATA);
    push_c(2'd0, 64'd0);
    req(0, 1'b0, 1'b1, 64'd1, WDATA);
    pulse();
    check("p0_ready_low_after_accept", 64'(rdy[0]), 64'd0);
    drain();
    push_g(1'b0, 64'd1, 64'd0);
    push_c(2'd0, WDATA);
    req(0, 1'b1, 1'b0, 64'd1, 64'd0);
    pulse();
    drain();

    // Preload 10..13 = 100..103 through p3, which leaves the RR pointer at 0
    for (int k = 0; k < 4; k++) begin
      push_g(1'b1, 64'(10 + k), 64'(100 + k));
      push_c(2'd3, 64'd0);
      req(3, 1'b0, 1'b1, 64'(10 + k), 64'(100 + k));
      pulse();
      drain();
    end

    // 3. all four ports read on the same cycle
    for (int k = 0; k < 4; k++) begin
      push_g(1'b0, 64'(10 + k), 64'd0);
      push_c(2'(k), 64'(100 + k));
    end
    for (int k = 0; k < 4; k++) req(k, 1'b1, 1'b0, 64'(10 + k), 64'd0);
    pulse();
    drain();

    // 4. p0 re-requests on completion while p1 is pending: grants 0,1,0,1
    push_g(1'b0, 64'd10, 64'd0); push_c(2'd0, 64'd100);
    push_g(1'b0, 64'd11, 64'd0); push_c(2'd1, 64'd101);
    push_g(1'b0, 64'd12, 64'd0); push_c(2'd0, 64'd102);
    push_g(1'b0, 64'd13, 64'd0); push_c(2'd1, 64'd103);
    req(0, 1'b1, 1'b0, 64'd10, 64'd0);
    req(1, 1'b1, 1'b0, 64'd11, 64'd0);
    pulse();
    wait_rise(0);
    req(0, 1'b1, 1'b0, 64'd12, 64'd0);
    pulse();
    wait_rise(1);
    req(1, 1'b1, 1'b0, 64'd13, 64'd0);
    pulse();
    drain();
    // The pointer is now 2, so p3 wins over p0 when both are pending.
    push_g(1'b0, 64'd13, 64'd0); push_c(2'd3, 64'd103);
    push_g(1'b0, 64'd10, 64'd0); push_c(2'd0, 64'd100);
    req(0, 1'b1, 1'b0, 64'd10, 64'd0);
    req(3, 1'b1, 1'b0, 64'd13, 64'd0);
    pulse();
    drain();

    // 5. a second p2 strobe while busy is ignored; p3 re+we becomes a write
    push_g(1'b0, 64'd1, 64'd0);
    push_c(2'd2, WDATA);
    req(2, 1'b1, 1'b0, 64'd1, 64'd0);
    pulse();
    req(2, 1'b1, 1'b0, 64'd13, 64'd0);
    pulse();
    drain();
    push_g(1'b1, 64'd20, 64'd7);
    push_c(2'd3, 64'd103);
    req(3, 1'b1, 1'b1, 64'd20, 64'd7);
    pulse();
    drain();
    push_g(1'b0, 64'd20, 64'd0);
    push_c(2'd3, 64'd7);
    req(3, 1'b1, 1'b0, 64'd20, 64'd0);
    pulse();
    drain();

    // 6. reset during WAIT with p1 and p2 pending
    m_lat = 10;
    push_g(1'b0, 64'd11, 64'd0);
    req(1, 1'b1, 1'b0, 64'd11, 64'd0);
    req(2, 1'b1, 1'b0, 64'd12, 64'd0);
    pulse();
    cyc = 0;
    while (exp_gnt_q.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_test_first_grant_seen", 64'(exp_gnt_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    check("state_wait_before_rst", 64'(dbg_state), 64'd2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_lat = 2;
    @(negedge clk);
    check("post_rst_ready", 64'(rdy), 64'hf);
    check("post_rst_mem_re", 64'(mem_re), 64'd0);
    check("post_rst_mem_we", 64'(mem_we), 64'd0);
    check("post_rst_p1_dout", dout_w[1], 64'd0);
    repeat (20) @(negedge clk);
    check("post_rst_still_idle", 64'(rdy), 64'hf);
    push_g(1'b0, 64'd11, 64'd0);
    push_c(2'd1, 64'd101);
    req(1, 1'b1, 1'b0, 64'd11, 64'd0);
    pulse();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
